// File: rtl/float_accum_seq_if.sv
// Handshake bundle between the float accumulator, its producer, one FloatAdder and the sum consumer.
// The master modport is the accumulator's view; slave is the environment's view.
interface float_accum_seq_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic [31:0]      add_op1;
  logic [31:0]      add_op2;
  logic             add_in_valid;
  logic [31:0]      add_result;
  logic             add_result_valid;
  logic             sum_valid;
  logic             sum_ready;
  logic [31:0]      sum_data;
  logic [CNT_W-1:0] sum_count;
  logic             error;

  modport master (
    input  in_valid, in_data, in_last, add_result, add_result_valid, sum_ready,
    output in_ready, add_op1, add_op2, add_in_valid, sum_valid, sum_data, sum_count, error
  );

  modport slave (
    output in_valid, in_data, in_last, add_result, add_result_valid, sum_ready,
    input  in_ready, add_op1, add_op2, add_in_valid, sum_valid, sum_data, sum_count, error
  );
endinterface

// File: rtl/float_accum_seq.sv
// Sequencer folding a stream of floats into a running sum through an external adder.
// One add in flight at a time; the adder is trusted for arithmetic, results pass through unmodified.
module float_accum_seq #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  float_accum_seq_if.master bus
);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_WAIT, S_DONE, S_ERR} state_e;

  state_e           state_q;
  logic [31:0]      sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TW-1:0]    timer_q;
  logic             last_q;
  logic             rv_q;
  logic [31:0]      op1_q, op2_q;
  logic             iv_q;
  logic             in_ready_q;
  logic             sum_valid_q;
  logic             err_q;

  logic in_xfer, res_edge;

  assign in_xfer  = bus.in_valid & in_ready_q;
  // Only a fresh rising edge counts: a level left high from a previous add must not be reused.
  assign res_edge = bus.add_result_valid & ~rv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      last_q      <= 1'b0;
      rv_q        <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      iv_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      sum_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rv_q <= bus.add_result_valid;
      iv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_xfer) begin
            sum_q <= bus.in_data;
            cnt_q <= CNT_W'(1);
            if (bus.in_last) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              sum_valid_q <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (in_xfer) begin
            op1_q      <= sum_q;
            op2_q      <= bus.in_data;
            iv_q       <= 1'b1;
            last_q     <= bus.in_last;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            timer_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          // A result edge in the expiry cycle still wins over the timeout.
          if (res_edge) begin
            sum_q <= bus.add_result;
            if (last_q) begin
              state_q     <= S_DONE;
              sum_valid_q <= 1'b1;
            end else begin
              state_q    <= S_ACCUM;
              in_ready_q <= 1'b1;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.sum_ready) begin
            state_q     <= S_IDLE;
            sum_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.add_op1      = op1_q;
  assign bus.add_op2      = op2_q;
  assign bus.add_in_valid = iv_q;
  assign bus.sum_valid    = sum_valid_q;
  assign bus.sum_data     = sum_q;
  assign bus.sum_count    = cnt_q;
  assign bus.error        = err_q;
endmodule

// File: tb/tb_float_accum_seq.sv
// Random and directed streams against a fold-based reference and a behavioural adder.
module tb_float_accum_seq;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  float_accum_seq_if #(.CNT_W(CNT_W)) bus ();

  float_accum_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Adder behaviour: known float sums from the directed cases, otherwise an arbitrary deterministic mix.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'h40400000) return 32'h40C00000;
    return a + b;
  endfunction

  logic        auto_en  = 1'b1;
  int          auto_lat = 3;
  int          pend     = 0;
  logic        auto_v   = 1'b0;
  logic [31:0] auto_r   = '0;
  logic [31:0] p1, p2;
  logic        man_v;
  logic [31:0] man_r;

  assign bus.add_result_valid = auto_v | man_v;
  assign bus.add_result       = man_v ? man_r : auto_r;

  always @(posedge clk) begin
    auto_v <= 1'b0;
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        auto_v <= 1'b1;
        auto_r <= fadd(p1, p2);
      end
    end
    if (auto_en && bus.add_in_valid) begin
      pend <= auto_lat;
      p1   <= bus.add_op1;
      p2   <= bus.add_op2;
    end
  end

  logic [63:0] iv_log[$];
  logic        prev_iv = 1'b0;
  int          dbl_iv  = 0;
  always @(posedge clk) begin
    if (bus.add_in_valid) begin
      iv_log.push_back({bus.add_op1, bus.add_op2});
      if (prev_iv) dbl_iv++;
    end
    prev_iv <= bus.add_in_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_elem(input logic [31:0] d, input logic last);
    int b = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && b < 300) begin
      tick();
      b++;
    end
    if (b >= 300) chk("in_ready_wait", 64'(b), 64'(0));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic release_sum();
    bus.sum_ready = 1'b1;
    tick();
    bus.sum_ready = 1'b0;
    chk("rel_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rel_sum_valid", 64'(bus.sum_valid), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_sum_valid", 64'(bus.sum_valid), 64'(0));
    chk("rst_error", 64'(bus.error), 64'(0));
  endtask

  logic [31:0] elems[$];

  task automatic run_stream(input int lat, input int hold);
    int b = 0;
    int base;
    logic [31:0] s;
    logic [31:0] d0;
    logic [CNT_W-1:0] c0;
    auto_en  = 1'b1;
    auto_lat = lat;
    base     = iv_log.size();
    for (int i = 0; i < elems.size(); i++) begin
      if (i > 0 && ($urandom_range(0, 1) == 1)) repeat ($urandom_range(1, 2)) tick();
      send_elem(elems[i], i == elems.size() - 1);
    end
    while (!bus.sum_valid && b < 300) begin
      tick();
      b++;
    end
    chk("sum_valid_wait", 64'(b >= 300), 64'(0));
    if (elems.size() == 1) chk("single_latency", 64'(b), 64'(0));
    s = elems[0];
    for (int i = 1; i < elems.size(); i++) begin
      if (base + i - 1 < iv_log.size())
        chk("issue_ops", iv_log[base + i - 1], {s, elems[i]});
      s = fadd(s, elems[i]);
    end
    chk("issue_cnt", 64'(iv_log.size() - base), 64'(elems.size() - 1));
    chk("sum_data", 64'(bus.sum_data), 64'(s));
    chk("sum_count", 64'(bus.sum_count), 64'(elems.size()));
    d0 = bus.sum_data;
    c0 = bus.sum_count;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 64'(bus.sum_valid), 64'(1));
      chk("hold_data", 64'(bus.sum_data), 64'(d0));
      chk("hold_count", 64'(bus.sum_count), 64'(c0));
      chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
    end
    release_sum();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.sum_ready = 1'b0;
    man_v         = 1'b0;
    man_r         = '0;
    #3;
    chk("reset_sum_valid", 64'(bus.sum_valid), 64'(0));
    chk("reset_iv", 64'(bus.add_in_valid), 64'(0));
    chk("reset_count", 64'(bus.sum_count), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    chk("post_reset_in_ready", 64'(bus.in_ready), 64'(1));

    // single element
    elems = '{32'h40400000};
    run_stream(3, 0);

    // three-element stream with 3-cycle adder, then 5 cycles of backpressure
    elems = '{32'h3F800000, 32'h40000000, 32'h40400000};
    run_stream(3, 5);

    // random streams
    for (int t = 0; t < 24; t++) begin
      int n;
      n = $urandom_range(1, 6);
      elems = {};
      for (int i = 0; i < n; i++) elems.push_back($urandom);
      run_stream($urandom_range(1, 5), $urandom_range(0, 3));
    end

    // timeout: adder never answers
    auto_en = 1'b0;
    send_elem(32'h11111111, 1'b0);
    send_elem(32'h22222222, 1'b1);
    chk("to_issue", 64'(bus.add_in_valid), 64'(1));
    repeat (TIMEOUT - 1) tick();
    chk("to_before", 64'(bus.error), 64'(0));
    tick();
    chk("to_error", 64'(bus.error), 64'(1));
    repeat (4) tick();
    chk("to_sticky", 64'(bus.error), 64'(1));
    chk("to_in_ready", 64'(bus.in_ready), 64'(0));
    chk("to_sum_valid", 64'(bus.sum_valid), 64'(0));
    do_reset();

    // stale level held across the issue is ignored until it drops and rises again
    send_elem(32'h00000100, 1'b0);
    man_v = 1'b1;
    man_r = 32'hDEAD0001;
    send_elem(32'h00000200, 1'b1);
    repeat (4) tick();
    chk("stale_ignored", 64'(bus.sum_valid), 64'(0));
    man_v = 1'b0;
    tick();
    man_v = 1'b1;
    man_r = 32'hBEEF0002;
    tick();
    man_v = 1'b0;
    chk("stale_accept", 64'(bus.sum_valid), 64'(1));
    chk("stale_data", 64'(bus.sum_data), 64'(32'hBEEF0002));
    chk("stale_count", 64'(bus.sum_count), 64'(2));
    release_sum();

    // result edge exactly in the expiry cycle wins
    send_elem(32'h00000300, 1'b0);
    send_elem(32'h00000400, 1'b1);
    repeat (TIMEOUT - 1) tick();
    man_v = 1'b1;
    man_r = 32'h12345678;
    tick();
    man_v = 1'b0;
    chk("expiry_valid", 64'(bus.sum_valid), 64'(1));
    chk("expiry_error", 64'(bus.error), 64'(0));
    chk("expiry_data", 64'(bus.sum_data), 64'(32'h12345678));
    release_sum();

    // reset while waiting; the late adder pulse must be ignored
    auto_en  = 1'b1;
    auto_lat = 4;
    send_elem(32'h3F800000, 1'b0);
    send_elem(32'h40000000, 1'b1);
    tick();
    rst_n = 1'b0;
    #2;
    chk("arst_op1", 64'(bus.add_op1), 64'(0));
    chk("arst_count", 64'(bus.sum_count), 64'(0));
    chk("arst_sum_valid", 64'(bus.sum_valid), 64'(0));
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("late_ignored", 64'(bus.sum_valid), 64'(0));
    chk("late_in_ready", 64'(bus.in_ready), 64'(1));
    elems = '{32'h3F800000};
    run_stream(3, 0);

    chk("iv_one_cycle", 64'(dbl_iv), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/float_accum_seq.md
Name: float_accum_seq

Overview:
- Initiator/sequencer that drives the single-precision float adder's operand/result handshake (Op1/Op2/InputValid in, Result/ResultValid out).
- Accepts a stream of IEEE-754 single floats. Issues one add per element against a running sum and waits for each adder result.
- Presents the final sum and element count when the element tagged last has been folded in.
- Sits between a producer stream and one FloatAdder instance.

Parameters:
- TIMEOUT, 64, max cycles allowed in WAIT for an adder result before ERR.
- CNT_W, 16, width of element counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- InValid  in  1  input element valid.
- InReady  out  1  block can accept an element.
- InData  in  32  float element (sign/exponent/mantissa packing as float type).
- InLast  in  1  element is last of stream.
- AddOp1  out  32  adder operand 1 (running sum).
- AddOp2  out  32  adder operand 2 (new element).
- AddInputValid  out  1  one-cycle issue strobe to adder.
- AddResult  in  32  adder result.
- AddResultValid  in  1  adder result valid (level or pulse).
- SumValid  out  1  final sum available.
- SumReady  in  1  consumer accepts sum.
- SumData  out  32  final sum.
- SumCount  out  CNT_W  elements accumulated.
- Error  out  1  sticky adder-timeout flag.

Behaviour:
- Reset (Reset=0, async): state IDLE. All outputs 0 except InReady=1 in IDLE after release. sum, count, timer, last_q, rv_q cleared.
- Transfer rules: input transfer = InValid&InReady; output transfer = SumValid&SumReady.
- rv_q registers AddResultValid every cycle. A result is accepted only on a rising edge (AddResultValid=1 & rv_q=0) while in WAIT. A level already high at issue is never taken as a new result.
- IDLE: InReady=1.
  - On transfer: sum<=InData, count<=1, no add issued.
  - InLast=1 -> DONE; else -> ACCUM.
- ACCUM: InReady=1.
  - On transfer: AddOp1<=sum, AddOp2<=InData, AddInputValid=1 for exactly the next cycle, last_q<=InLast, count<=count+1 (saturates at all-ones), timer<=0 -> WAIT.
- WAIT: InReady=0. AddOp1/AddOp2 held stable. timer increments each cycle.
  - On accepted result: sum<=AddResult; last_q ? DONE : ACCUM.
  - If timer reaches TIMEOUT-1 with no accepted result -> ERR.
  - A result edge in the same cycle as timer expiry wins (result accepted, no ERR).
- DONE: SumValid=1, SumData=sum, SumCount=count, InReady=0.
  - Hold all three stable until SumReady -> IDLE on the next cycle. Counter and sum are not cleared until the next IDLE transfer.
- ERR: Error=1, InReady=0, SumValid=0, AddInputValid=0. Exit only via Reset.
- Latency:
  - Single-element stream: InData transfer to SumValid = 1 cycle.
  - N elements: each add costs 1 issue cycle + adder latency + 1 capture cycle.
- Arithmetic: no float math in this block. Sum is whatever the adder returns, passed unmodified.
- Reset mid-operation: immediate return to IDLE. Any in-flight adder result arriving after release is ignored, since the state is not WAIT.

Test Plan:
1. Single element InData=0x40400000, InLast=1 -> no AddInputValid; next cycle SumValid=1, SumData=0x40400000, SumCount=1.
2. Stream 0x3F800000, 0x40000000, 0x40400000(last) with 3-cycle adder model:
   - First issue: AddOp1/AddOp2 = 0x3F800000/0x40000000.
   - Second issue: AddOp1/AddOp2 = 0x40400000/0x40400000.
   - Result: SumData=0x40C00000, SumCount=3.
   - Exactly two one-cycle AddInputValid pulses.
3. Backpressure: in DONE hold SumReady=0 for 5 cycles -> SumValid/SumData/SumCount stable and InReady=0; raise SumReady -> IDLE and InReady=1 next cycle.
4. Timeout: adder model never raises valid -> Error=1 exactly TIMEOUT cycles after the AddInputValid cycle; Error stays 1 and InReady=0 until Reset.
5. Stale level: AddResultValid held 1 across an issue -> not accepted; accepted only after it drops and rises again, else timeout.
6. Reset asserted in WAIT -> outputs cleared asynchronously the same cycle. Late adder valid after release is ignored. A new single-element stream of 0x3F800000 then yields SumData=0x3F800000, SumCount=1.
